core_bus_ctrl: RTL and testbench
================================

// Module: core_bus_ctrl
// PURPOSE
//  Parametrised memory-bus controller between the x86 core and board memories.
//  Replaces the single-bit PLL unlock and free-running core bus with:
//   - a lock-qualified core enable;
//   - address decode into BRAM, video RAM and SDRAM regions;
//   - per-region wait states, SDRAM req/ack handshake, and an SDRAM timeout with error flag.
//  Sits in the board top between pll/core and the memory blocks; runs on clock_25.
// PARAMETERS
//  ADDR_W      20      core address width
//  DATA_W      8       data width
//  RAM_SIZE    20'h10000  BRAM region: [0, RAM_SIZE)
//  VID_BASE    20'hB8000  video RAM base
//  VID_SIZE    20'h01000  video RAM size; all other addresses decode to SDRAM
//  RAM_LAT     1       BRAM/VRAM read latency in cycles (1..3)
//  LOCK_DELAY  16      consecutive cycles of locked=1 required before cpu_enable rises
//  SDR_TMO     255     cycles without sdram_ack before an SDRAM access is aborted
// PORTS
//  clock        in   1       system clock (clock_25)
//  reset_n      in   1       asynchronous, active-low reset
//  locked       in   1       PLL lock
//  cpu_enable   out  1       core clock enable
//  cpu_req      in   1       access request; held by the core until cpu_ready
//  cpu_wren     in   1       1 = write, 0 = read
//  cpu_address  in   ADDR_W  access address
//  cpu_out      in   DATA_W  write data from core
//  cpu_data     out  DATA_W  read data to core
//  cpu_ready    out  1       one-cycle completion strobe
//  bus_error    out  1       sticky SDRAM timeout flag
//  ram_address/ram_wdata/ram_wren  out   BRAM port; ram_rdata in DATA_W
//  vid_address/vid_wdata/vid_wren  out   VRAM port; vid_rdata in DATA_W
//  sdram_req/sdram_we    out  1
//  sdram_addr            out  ADDR_W
//  sdram_wdata           out  DATA_W
//  sdram_ack             in   1
//  sdram_rdata           in   DATA_W
// BEHAVIOUR
//  - Reset values: all outputs 0, FSM in IDLE, lock counter 0.
//  - Enable: lock counter increments while locked=1.
//    - cpu_enable=1 once the count reaches LOCK_DELAY.
//    - locked=0 clears the counter and drops cpu_enable the next cycle.
//    - Also aborts any access: FSM -> IDLE, sdram_req=0, no cpu_ready.
//  - cpu_req is ignored while cpu_enable=0.
//  - FSM states: IDLE, MEM_WAIT, SDR_REQ, DONE.
//    - IDLE: on cpu_req, register address, wdata and wren, then decode:
//      - BRAM/VRAM read -> MEM_WAIT, load counter with RAM_LAT.
//      - BRAM/VRAM write -> DONE; the *_wren pulse lasts exactly one cycle and
//        cpu_ready is asserted in that same cycle.
//      - SDRAM -> SDR_REQ.
//    - MEM_WAIT: count down; at 0, latch *_rdata into cpu_data, go to DONE
//      with cpu_ready=1. Read latency = RAM_LAT+1 cycles after the accepting edge.
//    - SDR_REQ: sdram_req held high with stable addr/we/wdata until sdram_ack.
//      - On ack: latch sdram_rdata (reads), go to DONE with cpu_ready=1.
//      - After SDR_TMO cycles without ack: drop req, cpu_data=all-ones,
//        bus_error=1, cpu_ready=1.
//      - An ack arriving in the timeout cycle wins: treated as a normal ack.
//    - DONE: one cycle, returns to IDLE. The minimum gap between back-to-back
//      accesses is one idle cycle.
//  - cpu_data holds its value until the next read completes; writes leave it unchanged.
//  - Address decode precedence: VRAM, then BRAM, then SDRAM.
//    - Region addresses are offsets from the region base, truncated to
//      $clog2(region size) bits.
//  - bus_error clears only on reset.
// STRUCTURE
//  - Package core_bus_pkg:
//    - region enum {REG_RAM, REG_VID, REG_SDR};
//    - FSM state typedef;
//    - default map constants RAM_SIZE, VID_BASE, VID_SIZE.
//  - Sub-module lock_enable_gen (locked -> cpu_enable counter, param LOCK_DELAY).
//  - Decode and FSM live in core_bus_ctrl.
// TESTING
//  1. locked=1 at t0 -> cpu_enable rises 16 cycles later; locked=0 for 1 cycle
//     -> cpu_enable=0 next cycle, count restarts.
//  2. Write 8'h5A to 20'h00010, then read it back -> ram_wren for 1 cycle with
//     ram_address=16'h0010; read returns cpu_data=8'h5A with cpu_ready 2 cycles
//     after acceptance (RAM_LAT=1).
//  3. Write 20'hB8002 = 8'h41 -> vid_wren=1, vid_address=12'h002; ram_wren and
//     sdram_req stay 0.
//  4. Read 20'h40000 with ack after 5 cycles and sdram_rdata=8'hC3
//     -> sdram_req high for 5 cycles, cpu_data=8'hC3, bus_error=0.
//  5. SDRAM read with no ack -> cpu_ready after 255 cycles, cpu_data=8'hFF,
//     bus_error=1 and sticky.
//  6. locked=0 mid-SDRAM access -> sdram_req=0 next cycle, no cpu_ready, FSM=IDLE.

Source files
------------

// File: rtl/core_bus_pkg.sv
// Shared types and default memory map for the core bus controller.
package core_bus_pkg;

    localparam int unsigned DEF_RAM_SIZE = 32'h0001_0000;
    localparam int unsigned DEF_VID_BASE = 32'h000B_8000;
    localparam int unsigned DEF_VID_SIZE = 32'h0000_1000;

    typedef enum logic [1:0] {
        REG_RAM,
        REG_VID,
        REG_SDR
    } region_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MEM_WAIT,
        ST_SDR_REQ,
        ST_DONE
    } bus_state_e;

endpackage

// File: rtl/lock_enable_gen.sv
// Core clock enable qualified by LOCK_DELAY consecutive cycles of PLL lock.
module lock_enable_gen #(
    parameter int unsigned LOCK_DELAY = 16
) (
    input  logic clock,
    input  logic reset_n,
    input  logic locked_i,
    output logic enable_o
);

    localparam int unsigned      CNT_W   = $clog2(LOCK_DELAY + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_DELAY);
    localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(LOCK_DELAY - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             enable_q, enable_d;

    // Saturating run-length of locked; enable rises on the edge the run reaches LOCK_DELAY.
    always_comb begin
        cnt_d    = '0;
        enable_d = 1'b0;
        if (locked_i) begin
            cnt_d    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
            enable_d = (cnt_q >= CNT_PRE);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q    <= '0;
            enable_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            enable_q <= enable_d;
        end
    end

    assign enable_o = enable_q;

endmodule

// File: rtl/core_bus_ctrl.sv
// Memory-bus controller: lock-qualified core enable, region decode, wait states,
// SDRAM req/ack handshake with timeout and sticky error flag.
module core_bus_ctrl
    import core_bus_pkg::*;
#(
    parameter int unsigned ADDR_W     = 20,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned RAM_SIZE   = DEF_RAM_SIZE,
    parameter int unsigned VID_BASE   = DEF_VID_BASE,
    parameter int unsigned VID_SIZE   = DEF_VID_SIZE,
    parameter int unsigned RAM_LAT    = 1,
    parameter int unsigned LOCK_DELAY = 16,
    parameter int unsigned SDR_TMO    = 255
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          locked,
    output logic                          cpu_enable,
    input  logic                          cpu_req,
    input  logic                          cpu_wren,
    input  logic [ADDR_W-1:0]             cpu_address,
    input  logic [DATA_W-1:0]             cpu_out,
    output logic [DATA_W-1:0]             cpu_data,
    output logic                          cpu_ready,
    output logic                          bus_error,
    output logic [$clog2(RAM_SIZE)-1:0]   ram_address,
    output logic [DATA_W-1:0]             ram_wdata,
    output logic                          ram_wren,
    input  logic [DATA_W-1:0]             ram_rdata,
    output logic [$clog2(VID_SIZE)-1:0]   vid_address,
    output logic [DATA_W-1:0]             vid_wdata,
    output logic                          vid_wren,
    input  logic [DATA_W-1:0]             vid_rdata,
    output logic                          sdram_req,
    output logic                          sdram_we,
    output logic [ADDR_W-1:0]             sdram_addr,
    output logic [DATA_W-1:0]             sdram_wdata,
    input  logic                          sdram_ack,
    input  logic [DATA_W-1:0]             sdram_rdata
);

    localparam int unsigned       RAM_AW   = $clog2(RAM_SIZE);
    localparam int unsigned       VID_AW   = $clog2(VID_SIZE);
    localparam int unsigned       LAT_W    = $clog2(RAM_LAT + 1);
    localparam int unsigned       TMO_W    = $clog2(SDR_TMO + 1);
    localparam logic [ADDR_W-1:0] RAM_LIM  = ADDR_W'(RAM_SIZE);
    localparam logic [ADDR_W-1:0] VID_LO   = ADDR_W'(VID_BASE);
    localparam logic [ADDR_W-1:0] VID_HI   = ADDR_W'(VID_BASE + VID_SIZE);
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(SDR_TMO - 1);

    bus_state_e          state_q, state_d;
    region_e             region_q, region_d, region_c;
    logic [LAT_W-1:0]    lat_q, lat_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic [DATA_W-1:0]   cpu_data_q, cpu_data_d;
    logic                cpu_ready_q, cpu_ready_d;
    logic                bus_error_q, bus_error_d;
    logic [RAM_AW-1:0]   ram_address_q, ram_address_d;
    logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
    logic                ram_wren_q, ram_wren_d;
    logic [VID_AW-1:0]   vid_address_q, vid_address_d;
    logic [DATA_W-1:0]   vid_wdata_q, vid_wdata_d;
    logic                vid_wren_q, vid_wren_d;
    logic                sdram_req_q, sdram_req_d;
    logic                sdram_we_q, sdram_we_d;
    logic [ADDR_W-1:0]   sdram_addr_q, sdram_addr_d;
    logic [DATA_W-1:0]   sdram_wdata_q, sdram_wdata_d;
    logic [VID_AW-1:0]   vid_off_c;

    lock_enable_gen #(
        .LOCK_DELAY (LOCK_DELAY)
    ) u_lock_enable (
        .clock    (clock),
        .reset_n  (reset_n),
        .locked_i (locked),
        .enable_o (cpu_enable)
    );

    // Region decode: VRAM wins over BRAM, everything else is SDRAM.
    always_comb begin
        vid_off_c = cpu_address[VID_AW-1:0] - VID_LO[VID_AW-1:0];
        if (cpu_address >= VID_LO && cpu_address < VID_HI) begin
            region_c = REG_VID;
        end else if (cpu_address < RAM_LIM) begin
            region_c = REG_RAM;
        end else begin
            region_c = REG_SDR;
        end
    end

    always_comb begin
        state_d       = state_q;
        region_d      = region_q;
        lat_d         = lat_q;
        tmo_d         = tmo_q;
        cpu_data_d    = cpu_data_q;
        cpu_ready_d   = 1'b0;
        bus_error_d   = bus_error_q;
        ram_address_d = ram_address_q;
        ram_wdata_d   = ram_wdata_q;
        ram_wren_d    = 1'b0;
        vid_address_d = vid_address_q;
        vid_wdata_d   = vid_wdata_q;
        vid_wren_d    = 1'b0;
        sdram_req_d   = 1'b0;
        sdram_we_d    = sdram_we_q;
        sdram_addr_d  = sdram_addr_q;
        sdram_wdata_d = sdram_wdata_q;

        // Loss of lock abandons any access in flight without a completion strobe.
        if (!locked) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cpu_enable && cpu_req) begin
                        region_d = region_c;
                        case (region_c)
                            REG_RAM: begin
                                ram_address_d = cpu_address[RAM_AW-1:0];
                                ram_wdata_d   = cpu_out;
                                ram_wren_d    = cpu_wren;
                            end
                            REG_VID: begin
                                vid_address_d = vid_off_c;
                                vid_wdata_d   = cpu_out;
                                vid_wren_d    = cpu_wren;
                            end
                            default: begin
                                sdram_addr_d  = cpu_address;
                                sdram_wdata_d = cpu_out;
                                sdram_we_d    = cpu_wren;
                                sdram_req_d   = 1'b1;
                            end
                        endcase
                        if (region_c == REG_SDR) begin
                            state_d = ST_SDR_REQ;
                            tmo_d   = '0;
                        end else if (cpu_wren) begin
                            state_d     = ST_DONE;
                            cpu_ready_d = 1'b1;
                        end else begin
                            state_d = ST_MEM_WAIT;
                            lat_d   = LAT_W'(RAM_LAT);
                        end
                    end
                end
                ST_MEM_WAIT: begin
                    if (lat_q == '0) begin
                        cpu_data_d  = (region_q == REG_VID) ? vid_rdata : ram_rdata;
                        cpu_ready_d = 1'b1;
                        state_d     = ST_DONE;
                    end else begin
                        lat_d = lat_q - LAT_W'(1);
                    end
                end
                ST_SDR_REQ: begin
                    // An ack in the final timeout cycle still counts as a normal completion.
                    if (sdram_ack) begin
                        if (!sdram_we_q) begin
                            cpu_data_d = sdram_rdata;
                        end
                        cpu_ready_d = 1'b1;
                        state_d     = ST_DONE;
                    end else if (tmo_q == TMO_LAST) begin
                        if (!sdram_we_q) begin
                            cpu_data_d = '1;
                        end
                        bus_error_d = 1'b1;
                        cpu_ready_d = 1'b1;
                        state_d     = ST_DONE;
                    end else begin
                        sdram_req_d = 1'b1;
                        tmo_d       = tmo_q + TMO_W'(1);
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            region_q      <= REG_RAM;
            lat_q         <= '0;
            tmo_q         <= '0;
            cpu_data_q    <= '0;
            cpu_ready_q   <= 1'b0;
            bus_error_q   <= 1'b0;
            ram_address_q <= '0;
            ram_wdata_q   <= '0;
            ram_wren_q    <= 1'b0;
            vid_address_q <= '0;
            vid_wdata_q   <= '0;
            vid_wren_q    <= 1'b0;
            sdram_req_q   <= 1'b0;
            sdram_we_q    <= 1'b0;
            sdram_addr_q  <= '0;
            sdram_wdata_q <= '0;
        end else begin
            state_q       <= state_d;
            region_q      <= region_d;
            lat_q         <= lat_d;
            tmo_q         <= tmo_d;
            cpu_data_q    <= cpu_data_d;
            cpu_ready_q   <= cpu_ready_d;
            bus_error_q   <= bus_error_d;
            ram_address_q <= ram_address_d;
            ram_wdata_q   <= ram_wdata_d;
            ram_wren_q    <= ram_wren_d;
            vid_address_q <= vid_address_d;
            vid_wdata_q   <= vid_wdata_d;
            vid_wren_q    <= vid_wren_d;
            sdram_req_q   <= sdram_req_d;
            sdram_we_q    <= sdram_we_d;
            sdram_addr_q  <= sdram_addr_d;
            sdram_wdata_q <= sdram_wdata_d;
        end
    end

    assign cpu_data    = cpu_data_q;
    assign cpu_ready   = cpu_ready_q;
    assign bus_error   = bus_error_q;
    assign ram_address = ram_address_q;
    assign ram_wdata   = ram_wdata_q;
    assign ram_wren    = ram_wren_q;
    assign vid_address = vid_address_q;
    assign vid_wdata   = vid_wdata_q;
    assign vid_wren    = vid_wren_q;
    assign sdram_req   = sdram_req_q;
    assign sdram_we    = sdram_we_q;
    assign sdram_addr  = sdram_addr_q;
    assign sdram_wdata = sdram_wdata_q;

endmodule

// File: tb/tb_core_bus_ctrl.sv
// Directed bench for core_bus_ctrl: event-schedule model of the bus plus literal checks.
module tb_core_bus_ctrl;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        locked;
    logic        cpu_enable;
    logic        cpu_req;
    logic        cpu_wren;
    logic [19:0] cpu_address;
    logic [7:0]  cpu_out;
    logic [7:0]  cpu_data;
    logic        cpu_ready;
    logic        bus_error;
    logic [15:0] ram_address;
    logic [7:0]  ram_wdata;
    logic        ram_wren;
    logic [7:0]  ram_rdata;
    logic [11:0] vid_address;
    logic [7:0]  vid_wdata;
    logic        vid_wren;
    logic [7:0]  vid_rdata;
    logic        sdram_req;
    logic        sdram_we;
    logic [19:0] sdram_addr;
    logic [7:0]  sdram_wdata;
    logic        sdram_ack;
    logic [7:0]  sdram_rdata;

    core_bus_ctrl dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .locked      (locked),
        .cpu_enable  (cpu_enable),
        .cpu_req     (cpu_req),
        .cpu_wren    (cpu_wren),
        .cpu_address (cpu_address),
        .cpu_out     (cpu_out),
        .cpu_data    (cpu_data),
        .cpu_ready   (cpu_ready),
        .bus_error   (bus_error),
        .ram_address (ram_address),
        .ram_wdata   (ram_wdata),
        .ram_wren    (ram_wren),
        .ram_rdata   (ram_rdata),
        .vid_address (vid_address),
        .vid_wdata   (vid_wdata),
        .vid_wren    (vid_wren),
        .vid_rdata   (vid_rdata),
        .sdram_req   (sdram_req),
        .sdram_we    (sdram_we),
        .sdram_addr  (sdram_addr),
        .sdram_wdata (sdram_wdata),
        .sdram_ack   (sdram_ack),
        .sdram_rdata (sdram_rdata)
    );

    always #5 clock = ~clock;

    // Board memories with one cycle of read latency.
    logic [7:0] bram [0:65535];
    logic [7:0] vram [0:4095];
    always @(posedge clock) begin
        if (ram_wren) bram[ram_address] <= ram_wdata;
        ram_rdata <= bram[ram_address];
        if (vid_wren) vram[vid_address] <= vid_wdata;
        vid_rdata <= vram[vid_address];
    end

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    int run_len = 0;

    // Scheduled expectations in units of cyc (edges since start).
    int exp_ready_at = -1;
    int exp_ramw_at  = -1;
    int exp_vidw_at  = -1;
    int req_from     = -1;
    int req_to       = -1;
    int pend_at      = -1;
    int err_at       = -1;
    logic [7:0] pend_val = 8'h00;
    logic [7:0] exp_data = 8'h00;
    logic       exp_err  = 1'b0;
    logic       cmp_en   = 1'b0;
    logic [7:0] exp_mem [int];

    int acc_cyc = 0;
    int last_ready_cyc = -1;
    int rdy_cnt = 0;
    int ramw_cnt = 0;
    int vidw_cnt = 0;
    int req_cnt = 0;
    logic [15:0] last_ram_addr = 16'h0;
    logic [11:0] last_vid_addr = 12'h0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (!reset_n) run_len <= 0;
        else          run_len <= locked ? run_len + 1 : 0;
    end

    // Per-cycle comparison against the scheduled model.
    always @(negedge clock) begin
        if (cmp_en) begin
            if (cyc == pend_at) exp_data = pend_val;
            if (cyc == err_at)  exp_err  = 1'b1;
            chk("cpu_enable", 32'(cpu_enable), 32'(run_len >= 16));
            chk("cpu_ready",  32'(cpu_ready),  32'(cyc == exp_ready_at));
            chk("ram_wren",   32'(ram_wren),   32'(cyc == exp_ramw_at));
            chk("vid_wren",   32'(vid_wren),   32'(cyc == exp_vidw_at));
            chk("sdram_req",  32'(sdram_req),  32'(cyc >= req_from && cyc < req_to));
            chk("cpu_data",   32'(cpu_data),   32'(exp_data));
            chk("bus_error",  32'(bus_error),  32'(exp_err));
            if (cpu_ready) begin last_ready_cyc = cyc; rdy_cnt++; end
            if (ram_wren)  begin ramw_cnt++; last_ram_addr = ram_address; end
            if (vid_wren)  begin vidw_cnt++; last_vid_addr = vid_address; end
            if (sdram_req) req_cnt++;
        end
    end

    function automatic int region_of(input logic [19:0] a);
        if (a >= 20'hB8000 && a < 20'hB9000) return 1;
        if (a < 20'h10000) return 0;
        return 2;
    endfunction

    task automatic clr_counts();
        rdy_cnt = 0; ramw_cnt = 0; vidw_cnt = 0; req_cnt = 0;
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) @(negedge clock);
    endtask

    // One core access; ack_after = edges after acceptance at which ack is sampled (0 = never).
    task automatic access(input logic [19:0] addr, input logic wr, input logic [7:0] wd,
                          input int ack_after, input logic [7:0] sd_rd);
        int a, done_at, rg;
        logic [19:0] off;
        @(negedge clock);
        clr_counts();
        cpu_req = 1'b1; cpu_wren = wr; cpu_address = addr; cpu_out = wd;
        a = cyc + 1;
        acc_cyc = a;
        rg = region_of(addr);
        if (rg == 2) begin
            done_at = (ack_after > 0) ? a + ack_after : a + 255;
            req_from = a; req_to = done_at;
            if (!wr) begin pend_at = done_at; pend_val = (ack_after > 0) ? sd_rd : 8'hFF; end
            if (ack_after == 0) err_at = done_at;
        end else if (wr) begin
            done_at = a;
            if (rg == 0) exp_ramw_at = a; else exp_vidw_at = a;
            exp_mem[int'(addr)] = wd;
        end else begin
            done_at = a + 2;
            pend_at = done_at;
            pend_val = exp_mem.exists(int'(addr)) ? exp_mem[int'(addr)] : 8'h00;
        end
        exp_ready_at = done_at;
        off = addr - 20'hB8000;
        while (cyc < done_at) begin
            @(negedge clock);
            sdram_ack = (ack_after > 0 && cyc == a + ack_after - 1);
            if (sdram_ack) sdram_rdata = sd_rd;
            if (rg == 2 && cyc < done_at) begin
                chk("sdram_addr", 32'(sdram_addr), 32'(addr));
                chk("sdram_we", 32'(sdram_we), 32'(wr));
                if (wr) chk("sdram_wdata", 32'(sdram_wdata), 32'(wd));
            end
            if (cyc == a && rg == 0) begin
                chk("ram_address", 32'(ram_address), 32'(addr[15:0]));
                if (wr) chk("ram_wdata", 32'(ram_wdata), 32'(wd));
            end
            if (cyc == a && rg == 1) begin
                chk("vid_address", 32'(vid_address), 32'(off[11:0]));
                if (wr) chk("vid_wdata", 32'(vid_wdata), 32'(wd));
            end
        end
        cpu_req = 1'b0;
        sdram_ack = 1'b0;
        #1;
    endtask

    initial begin
        int c0, g1, a;
        for (int i = 0; i < 65536; i++) bram[i] = 8'h00;
        for (int i = 0; i < 4096; i++) vram[i] = 8'h00;
        reset_n = 1'b0; locked = 1'b0; cpu_req = 1'b0; cpu_wren = 1'b0;
        cpu_address = 20'h0; cpu_out = 8'h0; sdram_ack = 1'b0; sdram_rdata = 8'h0;
        repeat (3) @(negedge clock);
        chk("rst_enable", 32'(cpu_enable), 32'd0);
        chk("rst_ready",  32'(cpu_ready),  32'd0);
        chk("rst_data",   32'(cpu_data),   32'd0);
        chk("rst_error",  32'(bus_error),  32'd0);
        chk("rst_sdreq",  32'(sdram_req),  32'd0);
        chk("rst_wren",   32'({ram_wren, vid_wren}), 32'd0);
        chk("rst_addr",   32'(sdram_addr), 32'd0);
        reset_n = 1'b1;
        cmp_en = 1'b1;

        // Request held while not enabled must be ignored.
        @(negedge clock);
        clr_counts();
        cpu_req = 1'b1; cpu_wren = 1'b1; cpu_address = 20'h00020; cpu_out = 8'hEE;
        locked = 1'b1;
        c0 = cyc;
        wait_to(c0 + 15);
        chk("t1_en_before", 32'(cpu_enable), 32'd0);
        cpu_req = 1'b0;
        wait_to(c0 + 16);
        chk("t1_en_rise", 32'(cpu_enable), 32'd1);
        chk("t1_ignored", 32'(ramw_cnt + rdy_cnt), 32'd0);
        @(negedge clock);
        locked = 1'b0;
        @(negedge clock);
        chk("t1_en_drop", 32'(cpu_enable), 32'd0);
        locked = 1'b1;
        g1 = cyc;
        wait_to(g1 + 15);
        chk("t1_en_rerise_before", 32'(cpu_enable), 32'd0);
        wait_to(g1 + 16);
        chk("t1_en_rerise", 32'(cpu_enable), 32'd1);

        access(20'h00010, 1'b1, 8'h5A, 0, 8'h00);
        chk("t2_wren_pulses", 32'(ramw_cnt), 32'd1);
        chk("t2_ram_addr", 32'(last_ram_addr), 32'h0010);
        access(20'h00010, 1'b0, 8'h00, 0, 8'h00);
        chk("t2_rdata", 32'(cpu_data), 32'h5A);
        chk("t2_latency", 32'(last_ready_cyc - acc_cyc), 32'd2);

        access(20'hB8002, 1'b1, 8'h41, 0, 8'h00);
        chk("t3_vid_addr", 32'(last_vid_addr), 32'h002);
        chk("t3_vid_pulses", 32'(vidw_cnt), 32'd1);
        chk("t3_no_ram_sdr", 32'(ramw_cnt + req_cnt), 32'd0);
        access(20'hB8002, 1'b0, 8'h00, 0, 8'h00);
        chk("t3_vid_rdata", 32'(cpu_data), 32'h41);

        // Decode boundaries.
        access(20'h0FFFF, 1'b1, 8'h77, 0, 8'h00);
        chk("bnd_ram_top", 32'(last_ram_addr), 32'hFFFF);
        access(20'h10000, 1'b1, 8'h12, 1, 8'h00);
        chk("bnd_sdr_write_keeps_data", 32'(cpu_data), 32'h41);
        access(20'hB7FFF, 1'b0, 8'h00, 2, 8'h3C);
        chk("bnd_below_vid", 32'(cpu_data), 32'h3C);
        access(20'hB8FFF, 1'b1, 8'h99, 0, 8'h00);
        chk("bnd_vid_top", 32'(last_vid_addr), 32'hFFF);
        access(20'hB9000, 1'b0, 8'h00, 1, 8'h5C);
        chk("bnd_above_vid", 32'(cpu_data), 32'h5C);

        access(20'h40000, 1'b0, 8'h00, 5, 8'hC3);
        chk("t4_req_cycles", 32'(req_cnt), 32'd5);
        chk("t4_rdata", 32'(cpu_data), 32'hC3);
        chk("t4_no_error", 32'(bus_error), 32'd0);

        access(20'h40001, 1'b0, 8'h00, 255, 8'h6E);
        chk("tmo_cycle_ack_data", 32'(cpu_data), 32'h6E);
        chk("tmo_cycle_ack_noerr", 32'(bus_error), 32'd0);

        access(20'h40002, 1'b0, 8'h00, 0, 8'h00);
        chk("t5_latency", 32'(last_ready_cyc - acc_cyc), 32'd255);
        chk("t5_data", 32'(cpu_data), 32'hFF);
        chk("t5_error", 32'(bus_error), 32'd1);
        access(20'h00010, 1'b0, 8'h00, 0, 8'h00);
        chk("t5_sticky", 32'(bus_error), 32'd1);
        chk("t5_after_rdata", 32'(cpu_data), 32'h5A);

        // Lock loss during an SDRAM access.
        @(negedge clock);
        clr_counts();
        cpu_req = 1'b1; cpu_wren = 1'b0; cpu_address = 20'h40003;
        a = cyc + 1;
        req_from = a; req_to = a + 2;
        wait_to(a + 1);
        locked = 1'b0;
        cpu_req = 1'b0;
        wait_to(a + 6);
        chk("t6_req_cycles", 32'(req_cnt), 32'd2);
        chk("t6_no_ready", 32'(rdy_cnt), 32'd0);
        locked = 1'b1;
        wait_to(cyc + 17);
        access(20'h0FFFF, 1'b0, 8'h00, 0, 8'h00);
        chk("t6_resume", 32'(cpu_data), 32'h77);

        repeat (2) @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
